can_rx_collector: RTL

CAN_RX_COLLECTOR -- requirements
Module: can_rx_collector

---
 rtl/can_rx_collector_pkg.sv | 23 ++
 rtl/can_rx_collector_if.sv | 32 +++
 rtl/rx_fifo.sv | 68 ++++++
 rtl/can_rx_collector.sv | 126 ++++++++++++
 4 files changed

// File: rtl/can_rx_collector_pkg.sv
// Shared defaults and the FIFO entry layout for the CAN receive collector.
package can_rx_collector_pkg;

    localparam int DEF_TOTAL_NODES = 4;
    localparam int DEF_DATA_SIZE   = 64;
    localparam int DEF_ID_SIZE     = 11;
    localparam int DEF_NODE_W      = $clog2(DEF_TOTAL_NODES);
    localparam int RXC_FIFO_DEPTH  = 8;

    typedef struct packed {
        logic [DEF_DATA_SIZE-1:0] packet;
        logic [DEF_ID_SIZE-1:0]   id;
        logic [DEF_NODE_W-1:0]    node;
    } rx_entry_t;

    // Overrun counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] base, input int unsigned inc);
        int unsigned total;
        total = 32'(base) + inc;
        return (total > 32'hFFFF) ? 16'hFFFF : total[15:0];
    endfunction

endpackage

// File: rtl/can_rx_collector_if.sv
// Output handshake bundle: collector drives the head frame, consumer drives ready.
interface can_rx_collector_if
    import can_rx_collector_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ID_SIZE   = DEF_ID_SIZE,
    parameter int NODE_W    = DEF_NODE_W
);

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_packet;
    logic [ID_SIZE-1:0]   out_id;
    logic [NODE_W-1:0]    out_node;

    modport master (
        output out_valid,
        output out_packet,
        output out_id,
        output out_node,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_packet,
        input  out_id,
        input  out_node,
        output out_ready
    );

endinterface

// File: rtl/rx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push is accepted when full
// only if a pop happens in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the consumer masks the head while empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == FULL_COUNT);

endmodule

// File: rtl/can_rx_collector.sv
// Collects frames from several CAN receivers into one ordered output stream,
// with one holding register per node and a round-robin arbiter feeding a FIFO.
module can_rx_collector
    import can_rx_collector_pkg::*;
#(
    parameter int Total_Nodes = DEF_TOTAL_NODES,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int ID_SIZE     = DEF_ID_SIZE,
    parameter int FIFO_DEPTH  = RXC_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [Total_Nodes-1:0]       data_out_req,
    input  logic [DATA_SIZE-1:0]         Rx_packet [Total_Nodes],
    input  logic [ID_SIZE-1:0]           Rx_ID     [Total_Nodes],
    can_rx_collector_if.master           out_bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [15:0]                  drop_count
);

    localparam int NODE_W  = $clog2(Total_Nodes);
    localparam int ENTRY_W = DATA_SIZE + ID_SIZE + NODE_W;

    logic [Total_Nodes-1:0] pending_q, pending_d;
    logic [DATA_SIZE-1:0]   hold_pkt_q [Total_Nodes];
    logic [DATA_SIZE-1:0]   hold_pkt_d [Total_Nodes];
    logic [ID_SIZE-1:0]     hold_id_q  [Total_Nodes];
    logic [ID_SIZE-1:0]     hold_id_d  [Total_Nodes];
    logic [NODE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]            drop_q, drop_d;

    logic                   grant_valid;
    logic [NODE_W-1:0]      grant_idx;
    logic                   fifo_full;
    logic                   pop;
    logic                   out_valid_int;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;
    int unsigned            n_drops;

    assign out_valid_int = (fifo_count != '0);
    assign pop           = out_valid_int && out_bus.out_ready;

    // Round-robin search starting at rr_ptr; a full FIFO only accepts when popping.
    always_comb begin
        logic [NODE_W-1:0] cand;
        int                sum;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        sum         = 0;
        for (int k = 0; k < Total_Nodes; k++) begin
            sum  = int'(rr_ptr_q) + k;
            cand = NODE_W'(sum % Total_Nodes);
            if (!grant_valid && pending_q[cand] && (!fifo_full || pop)) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        hold_pkt_d = hold_pkt_q;
        hold_id_d  = hold_id_q;
        rr_ptr_d   = rr_ptr_q;
        n_drops    = 0;
        if (grant_valid) begin
            pending_d[grant_idx] = 1'b0;
            rr_ptr_d = (grant_idx == NODE_W'(Total_Nodes - 1)) ? '0 : grant_idx + 1'b1;
        end
        // A granted node forwards its old frame this edge, so a new strobe is not an overrun.
        for (int i = 0; i < Total_Nodes; i++) begin
            if (data_out_req[i]) begin
                hold_pkt_d[i] = Rx_packet[i];
                hold_id_d[i]  = Rx_ID[i];
                pending_d[i]  = 1'b1;
                if (pending_q[i] && !(grant_valid && grant_idx == NODE_W'(i))) begin
                    n_drops = n_drops + 1;
                end
            end
        end
        drop_d = sat_add16(drop_q, n_drops);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            drop_q    <= '0;
            for (int i = 0; i < Total_Nodes; i++) begin
                hold_pkt_q[i] <= '0;
                hold_id_q[i]  <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
            hold_pkt_q <= hold_pkt_d;
            hold_id_q  <= hold_id_d;
        end
    end

    assign push_entry = {hold_pkt_q[grant_idx], hold_id_q[grant_idx], grant_idx};

    rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (grant_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign out_bus.out_valid  = out_valid_int;
    assign out_bus.out_packet = out_valid_int ? head_entry[ENTRY_W-1 -: DATA_SIZE]       : '0;
    assign out_bus.out_id     = out_valid_int ? head_entry[NODE_W +: ID_SIZE]            : '0;
    assign out_bus.out_node   = out_valid_int ? head_entry[NODE_W-1:0]                   : '0;
    assign drop_count         = drop_q;

endmodule
